// File: rtl/dsc_cache_ctrl.sv
// Descriptor cache controller: a 4-entry SRAM-backed circular FIFO feeding a
// 3-entry output buffer through a fixed 2-cycle SRAM read pipeline.
// Reads are only issued when the output buffer is guaranteed room.
module dsc_cache_ctrl (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [63:0] fill_data,
    output logic        dsc_valid,
    input  logic        dsc_ready,
    output logic [63:0] dsc_data,
    input  logic        flush,
    output logic [2:0]  level,
    output logic        empty,
    output logic        sram_blk_en,
    output logic        sram_w_en,
    output logic [1:0]  sram_w_addr,
    output logic [63:0] sram_w_data,
    output logic [1:0]  sram_r_addr,
    output logic        sram_r_addr_en,
    output logic        sram_r_data_en,
    input  logic [63:0] sram_r_data
);

    logic        r_blk_en;
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_sram_cnt;
    logic [1:0]  r_occ;
    logic        r_p1;      // read issued last cycle (data register enable stage)
    logic        r_p2;      // read data present on sram_r_data this cycle
    logic        r_valid;
    logic [2:0]  r_level;
    logic        r_empty;
    logic [63:0] r_buf [0:2];

    logic        w_run;
    logic        w_space;
    logic        w_fill;
    logic        w_pop;
    logic        w_issue;
    logic [2:0]  w_used;
    logic [2:0]  w_cnt_nxt;
    logic [1:0]  w_occ_nxt;
    logic [1:0]  w_wr_idx;
    logic [3:0]  w_sum;
    logic [2:0]  w_level_nxt;

    // Handshakes, read-issue credit decision and next-state occupancy values.
    always_comb begin
        w_run       = RESETN & r_blk_en;
        w_space     = (r_sram_cnt < 3'd4);
        w_fill      = w_run & ~flush & fill_valid & w_space;
        w_pop       = r_valid & dsc_ready & ~flush;
        // Slots already committed in the output buffer; a pop frees one now.
        w_used      = {1'b0, r_occ} + {2'b00, r_p1} + {2'b00, r_p2} - {2'b00, w_pop};
        // Entry must have been written in an earlier cycle (no bypass).
        w_issue     = w_run & ~flush & (r_sram_cnt != 3'd0) & (w_used < 3'd3);
        w_cnt_nxt   = r_sram_cnt + {2'b00, w_fill} - {2'b00, w_issue};
        w_occ_nxt   = r_occ + {1'b0, r_p2} - {1'b0, w_pop};
        w_wr_idx    = r_occ - {1'b0, w_pop};
        w_sum       = {1'b0, w_cnt_nxt} + {2'b00, w_occ_nxt} + {3'b000, w_issue} + {3'b000, r_p1};
        w_level_nxt = (w_sum > 4'd7) ? 3'd7 : w_sum[2:0];
    end

    // Port drive: SRAM strobes follow the handshakes, addresses/data idle at zero.
    always_comb begin
        fill_ready     = w_run & ~flush & w_space;
        sram_w_en      = w_fill;
        sram_w_addr    = w_fill ? r_wr_ptr : 2'd0;
        sram_w_data    = w_fill ? fill_data : 64'd0;
        sram_r_addr_en = w_issue;
        sram_r_addr    = w_issue ? r_rd_ptr : 2'd0;
        sram_r_data_en = r_p1;
        sram_blk_en    = r_blk_en;
        dsc_valid      = r_valid;
        dsc_data       = r_buf[0];
        level          = r_level;
        empty          = r_empty;
    end

    // Pointer, counter and read-pipeline state; flush wins over all traffic.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_blk_en   <= 1'b0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_sram_cnt <= 3'd0;
            r_occ      <= 2'd0;
            r_p1       <= 1'b0;
            r_p2       <= 1'b0;
            r_valid    <= 1'b0;
            r_level    <= 3'd0;
            r_empty    <= 1'b1;
        end else if (flush) begin
            r_blk_en   <= 1'b1;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_sram_cnt <= 3'd0;
            r_occ      <= 2'd0;
            r_p1       <= 1'b0;
            r_p2       <= 1'b0;
            r_valid    <= 1'b0;
            r_level    <= 3'd0;
            r_empty    <= 1'b1;
        end else begin
            r_blk_en   <= 1'b1;
            r_wr_ptr   <= r_wr_ptr + {1'b0, w_fill};
            r_rd_ptr   <= r_rd_ptr + {1'b0, w_issue};
            r_sram_cnt <= w_cnt_nxt;
            r_occ      <= w_occ_nxt;
            r_p1       <= w_issue;
            r_p2       <= r_p1;
            r_valid    <= (w_occ_nxt != 2'd0);
            r_level    <= w_level_nxt;
            r_empty    <= (w_sum == 4'd0);
        end
    end

    // Output buffer as a shift FIFO: entry 0 is the head driven on dsc_data,
    // so the head only moves on a pop or on a push into an empty buffer.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_buf[0] <= 64'd0;
            r_buf[1] <= 64'd0;
            r_buf[2] <= 64'd0;
        end else if (!flush) begin
            if (r_p2 && (w_wr_idx == 2'd0)) begin
                r_buf[0] <= sram_r_data;
            end else if (w_pop) begin
                r_buf[0] <= r_buf[1];
            end
            if (r_p2 && (w_wr_idx == 2'd1)) begin
                r_buf[1] <= sram_r_data;
            end else if (w_pop) begin
                r_buf[1] <= r_buf[2];
            end
            if (r_p2 && (w_wr_idx == 2'd2)) begin
                r_buf[2] <= sram_r_data;
            end
        end
    end

endmodule

// File: tb/tb_dsc_cache_ctrl.sv
// Testbench for dsc_cache_ctrl: directed scenarios plus randomized traffic,
// checked against a descriptor-queue reference model and a behavioural SRAM.
module tb_dsc_cache_ctrl;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        fill_valid;
    logic        fill_ready;
    logic [63:0] fill_data;
    logic        dsc_valid;
    logic        dsc_ready;
    logic [63:0] dsc_data;
    logic        flush;
    logic [2:0]  level;
    logic        empty;
    logic        sram_blk_en;
    logic        sram_w_en;
    logic [1:0]  sram_w_addr;
    logic [63:0] sram_w_data;
    logic [1:0]  sram_r_addr;
    logic        sram_r_addr_en;
    logic        sram_r_data_en;
    logic [63:0] sram_r_data;

    always #5 CLK = ~CLK;

    dsc_cache_ctrl dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .fill_valid     (fill_valid),
        .fill_ready     (fill_ready),
        .fill_data      (fill_data),
        .dsc_valid      (dsc_valid),
        .dsc_ready      (dsc_ready),
        .dsc_data       (dsc_data),
        .flush          (flush),
        .level          (level),
        .empty          (empty),
        .sram_blk_en    (sram_blk_en),
        .sram_w_en      (sram_w_en),
        .sram_w_addr    (sram_w_addr),
        .sram_w_data    (sram_w_data),
        .sram_r_addr    (sram_r_addr),
        .sram_r_addr_en (sram_r_addr_en),
        .sram_r_data_en (sram_r_data_en),
        .sram_r_data    (sram_r_data)
    );

    // 4x64 SRAM with registered read address and registered read data.
    logic [63:0] sram_mem [0:3];
    logic [1:0]  sram_addr_q  = 2'd0;
    logic [63:0] sram_rdata_q = 64'd0;
    assign sram_r_data = sram_rdata_q;

    always @(posedge CLK) begin
        if (sram_blk_en === 1'b1) begin
            if (sram_w_en) sram_mem[sram_w_addr] <= sram_w_data;
            if (sram_r_addr_en) sram_addr_q <= sram_r_addr;
            if (sram_r_data_en) sram_rdata_q <= sram_mem[sram_addr_q];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_pop   = 0;
    int n_acc   = 0;
    bit gen_chk = 1'b0;
    bit last_pop = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_issue = 1'b0;
    logic [63:0] prev_data = 64'd0;
    logic [63:0] q [$];   // descriptors accepted and not yet consumed, in order

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: inputs already driven by the caller at the negedge.
    task automatic cycle();
        bit hs_fill;
        bit hs_pop;
        bit ok;
        logic [63:0] fd;
        #1;
        if (gen_chk) begin
            check_val("level", 64'(level), 64'((q.size() > 7) ? 7 : q.size()));
            check_val("empty", 64'(empty), 64'(q.size() == 0));
            if (prev_stall) begin
                check_val("hold_valid", 64'(dsc_valid), 64'd1);
                check_val("hold_data", dsc_data, prev_data);
            end
            check_val("rd_data_en", 64'(sram_r_data_en), 64'(prev_issue));
        end
        hs_fill = fill_valid && fill_ready;
        hs_pop  = dsc_valid && dsc_ready;
        ok      = RESETN && !flush;
        fd      = fill_data;
        if (gen_chk && hs_pop) begin
            if (q.size() == 0) check_val("pop_spurious", 64'(dsc_valid & dsc_ready), 64'd0);
            else check_val("dsc_order", dsc_data, q[0]);
        end
        prev_stall = dsc_valid && !dsc_ready && ok;
        prev_data  = dsc_data;
        prev_issue = sram_r_addr_en;
        @(posedge CLK);
        last_pop = hs_pop && ok;
        if (!ok) begin
            q.delete();
        end else begin
            if (hs_pop && q.size() > 0) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (hs_fill) begin
                q.push_back(fd);
                n_acc++;
            end
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_fill_ready"}, 64'(fill_ready), 64'd0);
        check_val({pfx, "_dsc_valid"}, 64'(dsc_valid), 64'd0);
        check_val({pfx, "_w_en"}, 64'(sram_w_en), 64'd0);
        check_val({pfx, "_r_addr_en"}, 64'(sram_r_addr_en), 64'd0);
        check_val({pfx, "_r_data_en"}, 64'(sram_r_data_en), 64'd0);
        check_val({pfx, "_blk_en"}, 64'(sram_blk_en), 64'd0);
        check_val({pfx, "_level"}, 64'(level), 64'd0);
        check_val({pfx, "_empty"}, 64'(empty), 64'd1);
        check_val({pfx, "_dsc_data"}, dsc_data, 64'd0);
        check_val({pfx, "_w_addr"}, 64'(sram_w_addr), 64'd0);
        check_val({pfx, "_w_data"}, sram_w_data, 64'd0);
        check_val({pfx, "_r_addr"}, 64'(sram_r_addr), 64'd0);
    endtask

    // Fill n_fill words with the consumer stalled, wait, then flush.
    task automatic do_flush(input int n_fill, input int n_wait, input logic [63:0] tag_base);
        int p0;
        dsc_ready = 1'b0;
        for (int i = 0; i < n_fill; i++) begin
            fill_valid = 1'b1;
            fill_data  = tag_base + 64'(i);
            cycle();
        end
        fill_valid = 1'b0;
        for (int i = 0; i < n_wait; i++) cycle();
        flush      = 1'b1;
        fill_valid = 1'b1;
        fill_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        dsc_ready  = 1'b1;
        #1;
        check_val("flush_fill_ready", 64'(fill_ready), 64'd0);
        check_val("flush_w_en", 64'(sram_w_en), 64'd0);
        check_val("flush_r_addr_en", 64'(sram_r_addr_en), 64'd0);
        cycle();
        flush      = 1'b0;
        fill_valid = 1'b0;
        #1;
        check_val("post_flush_valid", 64'(dsc_valid), 64'd0);
        check_val("post_flush_level", 64'(level), 64'd0);
        check_val("post_flush_empty", 64'(empty), 64'd1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("late_data_hidden", 64'(dsc_valid), 64'd0);
            cycle();
        end
        p0 = n_pop;
        fill_valid = 1'b1;
        fill_data  = tag_base ^ 64'h00C0_FFEE_0000_0000;
        cycle();
        fill_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check_val("flush_refill_pops", 64'(n_pop - p0), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int a0;
        int start;
        int first;
        int last;
        int sent;
        int guard;
        bit hit;
        RESETN     = 1'b0;
        fill_valid = 1'b0;
        fill_data  = 64'd0;
        dsc_ready  = 1'b0;
        flush      = 1'b0;
        @(negedge CLK);
        cycle();
        cycle();
        // Reset values while RESETN is held low.
        #1;
        check_reset_vals("rst");
        cycle();
        RESETN = 1'b1;
        cycle();
        #1;
        check_val("rel_blk_en", 64'(sram_blk_en), 64'd1);
        check_val("rel_fill_ready", 64'(fill_ready), 64'd1);
        gen_chk = 1'b1;

        // Single descriptor latency.
        fill_valid = 1'b1;
        fill_data  = 64'h0123_4567_89AB_CDEF;
        dsc_ready  = 1'b1;
        #1;
        check_val("single_w_en", 64'(sram_w_en), 64'd1);
        check_val("single_w_addr", 64'(sram_w_addr), 64'd0);
        check_val("single_w_data", sram_w_data, 64'h0123_4567_89AB_CDEF);
        cycle();
        fill_valid = 1'b0;
        #1;
        check_val("single_issue_c1", 64'(sram_r_addr_en), 64'd1);
        check_val("single_r_addr", 64'(sram_r_addr), 64'd0);
        cycle();
        #1;
        check_val("single_data_en_c2", 64'(sram_r_data_en), 64'd1);
        cycle();
        #1;
        check_val("single_valid_c3", 64'(dsc_valid), 64'd0);
        cycle();
        #1;
        check_val("single_valid_c4", 64'(dsc_valid), 64'd1);
        check_val("single_data_c4", dsc_data, 64'h0123_4567_89AB_CDEF);
        cycle();
        #1;
        check_val("single_empty_c5", 64'(empty), 64'd1);
        cycle();

        // Full: stall the consumer and fill until back-pressure.
        p0  = n_pop;
        a0  = n_acc;
        hit = 1'b0;
        dsc_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fill_valid = 1'b1;
            fill_data  = 64'hF000 + 64'(i);
            #1;
            if (!fill_ready) begin
                hit = 1'b1;
                break;
            end
            cycle();
        end
        check_val("full_backpressure", 64'(fill_ready), 64'd0);
        check_val("full_level", 64'(level), 64'd7);
        check_val("full_seen", 64'(hit), 64'd1);
        fill_valid = 1'b0;
        cycle();
        dsc_ready = 1'b1;
        for (int i = 0; i < 15; i++) cycle();
        check_val("full_drain_empty", 64'(empty), 64'd1);
        check_val("full_no_loss", 64'(n_pop - p0), 64'(n_acc - a0));

        // Flush with reads in flight, then with a full output buffer.
        do_flush(3, 0, 64'hA000_0000_0000_0000);
        do_flush(6, 5, 64'hB000_0000_0000_0000);

        // Streaming 0..63 with both sides always ready.
        start = cyc;
        first = -1;
        last  = -1;
        sent  = 0;
        p0    = n_pop;
        dsc_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            int c;
            int a;
            fill_valid = (sent < 64);
            fill_data  = 64'(sent);
            c = cyc;
            a = n_acc;
            cycle();
            if (n_acc != a) sent++;
            if (last_pop) begin
                if (first < 0) first = c;
                last = c;
            end
            if (n_pop - p0 == 64) break;
        end
        fill_valid = 1'b0;
        check_val("stream_count", 64'(n_pop - p0), 64'd64);
        check_val("stream_latency", 64'(first - start), 64'd4);
        check_val("stream_rate", 64'(last - first), 64'd63);
        cycle();

        // Random fills against random consumer back-pressure.
        a0    = n_acc;
        p0    = n_pop;
        guard = 0;
        while ((n_acc - a0) < 200 && guard < 3000) begin
            fill_valid = ($urandom_range(0, 1) == 1);
            fill_data  = {$urandom, $urandom};
            dsc_ready  = ($urandom_range(0, 1) == 1);
            cycle();
            guard++;
        end
        fill_valid = 1'b0;
        dsc_ready  = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        check_val("rand_accepted", 64'(n_acc - a0), 64'd200);
        check_val("rand_delivered", 64'(n_pop - p0), 64'd200);
        check_val("rand_empty", 64'(empty), 64'd1);

        // Reset pulse in the middle of a stream.
        dsc_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fill_valid = 1'b1;
            fill_data  = 64'h5000 + 64'(i);
            cycle();
        end
        RESETN = 1'b0;
        cycle();
        RESETN     = 1'b1;
        fill_valid = 1'b1;
        fill_data  = 64'hDEAD;
        #1;
        check_reset_vals("midrst");
        cycle();
        p0 = n_pop;
        fill_data = 64'hA5;
        #1;
        check_val("midrst_blk_en", 64'(sram_blk_en), 64'd1);
        check_val("midrst_fill_ready", 64'(fill_ready), 64'd1);
        cycle();
        fill_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check_val("midrst_single_pop", 64'(n_pop - p0), 64'd1);
        check_val("midrst_empty", 64'(empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
